// File: rtl/hdmi_video_pkg.sv
// hdmi_video_pkg: 720p60 timing constants, aligner FSM states and colour bars.
// Shared by hdmi_pixel_aligner and its testbench.
package hdmi_video_pkg;

  localparam int VID_H_ACTIVE = 1280;
  localparam int VID_H_FP     = 110;
  localparam int VID_H_SYNC   = 40;
  localparam int VID_H_BP     = 220;
  localparam int VID_V_ACTIVE = 720;
  localparam int VID_V_FP     = 5;
  localparam int VID_V_SYNC   = 5;
  localparam int VID_V_BP     = 20;

  localparam int H_TOTAL =
    VID_H_ACTIVE + VID_H_FP + VID_H_SYNC + VID_H_BP;
  localparam int V_TOTAL =
    VID_V_ACTIVE + VID_V_FP + VID_V_SYNC + VID_V_BP;

  localparam logic VID_SYNC_POL = 1'b1;
  localparam int   VID_BUF_AW   = 11;
  localparam int   VID_PREFILL  = 1280;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_RESYNC = 2'd2
  } state_e;

  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] C_CYAN    = 24'h00FFFF;
  localparam logic [23:0] C_GREEN   = 24'h00FF00;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_BLUE    = 24'h0000FF;
  localparam logic [23:0] C_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_color(
    input logic [2:0] idx
  );
    logic [23:0] c;
    c = C_BLACK;
    unique case (idx)
      3'd0: c = C_WHITE;
      3'd1: c = C_YELLOW;
      3'd2: c = C_CYAN;
      3'd3: c = C_GREEN;
      3'd4: c = C_MAGENTA;
      3'd5: c = C_RED;
      3'd6: c = C_BLUE;
      3'd7: c = C_BLACK;
      default: c = C_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pixel_fwft_fifo.sv
// pixel_fwft_fifo: single-clock first-word-fall-through pixel buffer.
// Flush resets both pointers and discards a same-cycle write.
module pixel_fwft_fifo #(
  parameter int DW = 24,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign rdata   = mem[rd_ptr];

  // Storage array; no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        level <= level + 1'b1;
      else if (do_pop && !do_push)
        level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/hdmi_pixel_aligner.sv
// hdmi_pixel_aligner: 720p raster timing plus prefilled pixel release.
// Optional colour-bar generator under HDMI_ALIGNER_PATTERN_EN.
module hdmi_pixel_aligner
  import hdmi_video_pkg::*;
#(
  parameter int   H_ACTIVE = VID_H_ACTIVE,
  parameter int   H_FP     = VID_H_FP,
  parameter int   H_SYNC   = VID_H_SYNC,
  parameter int   H_BP     = VID_H_BP,
  parameter int   V_ACTIVE = VID_V_ACTIVE,
  parameter int   V_FP     = VID_V_FP,
  parameter int   V_SYNC   = VID_V_SYNC,
  parameter int   V_BP     = VID_V_BP,
  parameter logic SYNC_POL = VID_SYNC_POL,
  parameter int   BUF_AW   = VID_BUF_AW,
  parameter int   PREFILL  = VID_PREFILL
) (
  input  logic              i_hdmi_clk,
  input  logic              i_rst_n,
  input  logic [23:0]       i_rgb8,
  input  logic              i_rgb8_valid,
  input  logic              i_clr_err,
`ifdef HDMI_ALIGNER_PATTERN_EN
  input  logic              i_pattern_sel,
`endif
  output logic [23:0]       o_rgb8,
  output logic              o_de,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic [BUF_AW:0]   o_buf_level,
  output logic              o_streaming,
  output logic              o_underflow,
  output logic              o_overflow
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BUF_AW:0] PF   = (BUF_AW+1)'(PREFILL);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  state_e        state;
  state_e        state_nxt;

  logic          active;
  logic          frame_end;
  logic          hs_on;
  logic          vs_on;
  logic          pat;
  logic          pop;
  logic          under;
  logic          ovf;
  logic          flush;
  logic [23:0]   head;
  logic [23:0]   bar;
  logic [23:0]   rgb_nxt;
  logic          full;
  logic          empty;
  logic          in_stream;

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign hs_on     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_on     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

`ifdef HDMI_ALIGNER_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic [HW-1:0] bar_q;
  assign pat   = i_pattern_sel;
  assign bar_q = h_cnt / HW'(BAR_W);
  assign bar   = bar_color(bar_q[2:0]);
`else
  assign pat = 1'b0;
  assign bar = '0;
`endif

  assign in_stream = (state == ST_STREAM);
  assign pop   = in_stream && active && !empty && !pat;
  assign under = in_stream && active && empty && !pat;
  assign flush = (state == ST_RESYNC) && frame_end && !pat;
  assign ovf   = i_rgb8_valid && full && !pop;

  assign o_streaming = in_stream;

  pixel_fwft_fifo #(
    .DW (24),
    .AW (BUF_AW)
  ) u_fifo (
    .clk   (i_hdmi_clk),
    .rst_n (i_rst_n),
    .flush (flush),
    .push  (i_rgb8_valid),
    .wdata (i_rgb8),
    .pop   (pop),
    .rdata (head),
    .level (o_buf_level),
    .full  (full),
    .empty (empty)
  );

  // Next FSM state; frozen while the test pattern is shown.
  always_comb begin
    state_nxt = state;
    if (!pat) begin
      unique case (1'b1)
        (state == ST_IDLE):
          if (frame_end && o_buf_level >= PF)
            state_nxt = ST_STREAM;
        (state == ST_STREAM):
          if (under) state_nxt = ST_RESYNC;
        (state == ST_RESYNC):
          if (frame_end) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Pixel selection for the next output register.
  always_comb begin
    rgb_nxt = '0;
    if (pat && active) rgb_nxt = bar;
    else if (pop)      rgb_nxt = head;
  end

  // Free-running raster counters.
  always_ff @(posedge i_hdmi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge i_hdmi_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Registered video outputs, mutually aligned.
  always_ff @(posedge i_hdmi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rgb8  <= '0;
      o_de    <= 1'b0;
      o_hsync <= ~SYNC_POL;
      o_vsync <= ~SYNC_POL;
    end else begin
      o_rgb8  <= rgb_nxt;
      o_de    <= active;
      o_hsync <= hs_on ? SYNC_POL : ~SYNC_POL;
      o_vsync <= vs_on ? SYNC_POL : ~SYNC_POL;
    end
  end

  // Sticky error flags; a new event beats a clear.
  always_ff @(posedge i_hdmi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_underflow <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      if (under)          o_underflow <= 1'b1;
      else if (i_clr_err) o_underflow <= 1'b0;
      if (ovf)            o_overflow  <= 1'b1;
      else if (i_clr_err) o_overflow  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hdmi_pixel_aligner.sv
// tb_hdmi_pixel_aligner: self-checking bench on a shrunken raster.
// H 16/2/3/3 (24 clk), V 4/1/1/1 (7 lines), 32-deep buffer, prefill 16.
module tb_hdmi_pixel_aligner;

  localparam int HT = 24;
  localparam int FR = HT * 7;

  logic        clk;
  logic        rst_n;
  logic [23:0] rgb_in;
  logic        valid;
  logic        clr;
  logic [23:0] rgb;
  logic        de;
  logic        hs;
  logic        vs;
  logic [5:0]  lvl;
  logic        strm;
  logic        unf;
  logic        ovf;
`ifdef HDMI_ALIGNER_PATTERN_EN
  logic        psel;
`endif

  hdmi_pixel_aligner #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4),  .V_FP (1), .V_SYNC (1), .V_BP (1),
    .SYNC_POL (1'b1), .BUF_AW (5), .PREFILL (16)
  ) dut (
    .i_hdmi_clk   (clk),
    .i_rst_n      (rst_n),
    .i_rgb8       (rgb_in),
    .i_rgb8_valid (valid),
    .i_clr_err    (clr),
`ifdef HDMI_ALIGNER_PATTERN_EN
    .i_pattern_sel(psel),
`endif
    .o_rgb8       (rgb),
    .o_de         (de),
    .o_hsync      (hs),
    .o_vsync      (vs),
    .o_buf_level  (lvl),
    .o_streaming  (strm),
    .o_underflow  (unf),
    .o_overflow   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int k = 0;
  logic [23:0] sb[$];

  typedef struct {
    int   t;
    logic de;
    logic hs;
    logic vs;
  } tvec_t;

  tvec_t tbl[14];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (k=%0d)",
               nm, act, exp, k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic run_to(input int kk);
    while (k < kk) tick();
  endtask

  function automatic logic [23:0] pv(input int i);
    return 24'hA50000 | 24'(i);
  endfunction

  initial begin
    logic got;
    logic [23:0] e;

    tbl[0]  = '{0,   1'b1, 1'b0, 1'b0};
    tbl[1]  = '{15,  1'b1, 1'b0, 1'b0};
    tbl[2]  = '{16,  1'b0, 1'b0, 1'b0};
    tbl[3]  = '{17,  1'b0, 1'b0, 1'b0};
    tbl[4]  = '{18,  1'b0, 1'b1, 1'b0};
    tbl[5]  = '{20,  1'b0, 1'b1, 1'b0};
    tbl[6]  = '{21,  1'b0, 1'b0, 1'b0};
    tbl[7]  = '{72,  1'b1, 1'b0, 1'b0};
    tbl[8]  = '{95,  1'b0, 1'b0, 1'b0};
    tbl[9]  = '{96,  1'b0, 1'b0, 1'b0};
    tbl[10] = '{119, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{120, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{144, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{168, 1'b1, 1'b0, 1'b0};

    rst_n  = 1'b0;
    rgb_in = '0;
    valid  = 1'b0;
    clr    = 1'b0;
`ifdef HDMI_ALIGNER_PATTERN_EN
    psel   = 1'b0;
`endif
    #22;
    check("rst_video", {5'b0, de, hs, vs, rgb}, 32'h0);
    check("rst_state", {26'b0, lvl, strm, unf, ovf}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;

    // raster timing, no input
    for (int i = 0; i < 14; i++) begin
      run_to(tbl[i].t + 1);
      check($sformatf("timing_t%0d", tbl[i].t),
            {29'b0, de, hs, vs},
            {29'b0, tbl[i].de, tbl[i].hs, tbl[i].vs});
      check("idle_dark", {7'b0, strm, rgb}, 32'h0);
    end

    // prefill one line mid-frame
    for (int i = 0; i < 16; i++) begin
      valid  = 1'b1;
      rgb_in = pv(i);
      sb.push_back(pv(i));
      tick();
    end
    valid = 1'b0;
    check("prefill_level", 32'(lvl), 32'd16);
    run_to(2 * FR - 1);
    check("idle_until_end", 32'(strm), 32'd0);
    tick();
    check("stream_at_end", 32'(strm), 32'd1);

    // drain line 0, underflow on line 1 pixel 0
    got = 1'b0;
    for (int n = 0; n < 3 * HT && !got; n++) begin
      tick();
      if (de) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("stream_px", 32'(rgb), 32'(e));
          check("stream_flag", 32'(strm), 32'd1);
        end else begin
          got = 1'b1;
          check("unf_px", 32'(rgb), 32'h0);
          check("unf_flag", 32'(unf), 32'd1);
          check("unf_resync", 32'(strm), 32'd0);
          check("unf_time", 32'(k), 32'(2 * FR + HT + 1));
        end
      end
    end
    if (!got) begin
      n_chk++;
      n_err++;
      $display("FAIL underflow_timeout: got none want one");
    end

    // writes in RESYNC are flushed at frame end
    for (int i = 0; i < 5; i++) begin
      valid  = 1'b1;
      rgb_in = 24'h123456;
      tick();
    end
    valid = 1'b0;
    run_to(3 * FR - 1);
    check("resync_level", 32'(lvl), 32'd5);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("flush_level", 32'(lvl), 32'd0);
    check("flush_idle", 32'(strm), 32'd0);

    // fill to full, then one dropped write
    for (int i = 0; i < 32; i++) begin
      valid  = 1'b1;
      rgb_in = pv(100 + i);
      sb.push_back(pv(100 + i));
      tick();
    end
    check("full_level", 32'(lvl), 32'd32);
    check("full_no_ovf", 32'(ovf), 32'd0);
    rgb_in = 24'hDEAD00;
    tick();
    valid = 1'b0;
    check("ovf_level", 32'(lvl), 32'd32);
    check("ovf_flag", 32'(ovf), 32'd1);
    check("unf_sticky", 32'(unf), 32'd1);
    clr = 1'b1;
    tick();
    check("clr_ovf", 32'(ovf), 32'd0);
    check("clr_unf", 32'(unf), 32'd0);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("set_wins", 32'(ovf), 32'd1);
    tick();
    clr = 1'b0;
    check("clr_again", 32'(ovf), 32'd0);

    // stream from full with push+pop on the first pixel
    run_to(4 * FR - 1);
    check("idle_full", 32'(strm), 32'd0);
    tick();
    check("stream_full", 32'(strm), 32'd1);
    valid  = 1'b1;
    rgb_in = 24'h00BEEF;
    sb.push_back(24'h00BEEF);
    for (int n = 0; n < 6; n++) begin
      tick();
      valid = 1'b0;
      if (k == 4 * FR + 1)
        check("full_pushpop", 32'(lvl), 32'd32);
      if (de) begin
        e = sb.pop_front();
        check("stream2_px", 32'(rgb), 32'(e));
      end else begin
        check("stream2_de", 32'(de), 32'd1);
      end
    end

    // asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_video", {5'b0, de, hs, vs, rgb}, 32'h0);
    check("arst_state", {26'b0, lvl, strm, unf, ovf}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    tick();
    check("post_rst_de", 32'(de), 32'd1);
    check("post_rst_lvl", 32'(lvl), 32'd0);

`ifdef HDMI_ALIGNER_PATTERN_EN
    psel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1;
      rgb_in = 24'h777777;
      tick();
    end
    valid = 1'b0;
    run_to(FR + 1);
    check("bar_px0", 32'(rgb), 32'hFFFFFF);
    run_to(FR + 3);
    check("bar_px2", 32'(rgb), 32'hFFFF00);
    run_to(FR + 16);
    check("bar_last", 32'(rgb), 32'h000000);
    check("bar_level", 32'(lvl), 32'd3);
    psel = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hdmi_pixel_aligner.md
Name: hdmi_pixel_aligner

Overview:
Consumes the RGB888 pixel stream (24-bit data plus valid, no back-pressure) from the pixel buffer stage in the HDMI clock domain. Buffers pixels and generates 720p60 raster timing (DE/HSYNC/VSYNC). Releases pixels to the TMDS encoder only after a full line is prefilled, so stale data never reaches the encoder. Sits between pixel buffer and TMDS encoder.

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (clocks)
H_SYNC, 40, hsync width
H_BP, 220, horizontal back porch
V_ACTIVE, 720, active lines
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vsync width
V_BP, 20, vertical back porch
SYNC_POL, 1, asserted level of hsync/vsync
BUF_AW, 11, buffer address width; depth = 2**BUF_AW = 2048
PREFILL, 1280, buffer level required before streaming

Ports:
i_hdmi_clk  in  1  pixel clock, 74.25 MHz; the block's only clock
i_rst_n  in  1  asynchronous, active-low reset
i_rgb8  in  24  {R,G,B} pixel from upstream
i_rgb8_valid  in  1  i_rgb8 valid this cycle
i_clr_err  in  1  synchronous clear of sticky error flags
o_rgb8  out  24  pixel to encoder; 0 whenever o_de=0
o_de  out  1  active-video enable
o_hsync  out  1  horizontal sync
o_vsync  out  1  vertical sync
o_buf_level  out  BUF_AW+1  current buffer occupancy
o_streaming  out  1  high in STREAM state
o_underflow  out  1  sticky: buffer empty during active pixel
o_overflow  out  1  sticky: write dropped because buffer full

Behaviour:
- Reset (async assert, sync deassert assumed upstream): counters h=0, v=0, state IDLE, buffer empty, all outputs 0 except syncs = ~SYNC_POL.
- Timing: h_cnt 0..H_TOTAL-1 (1650), v_cnt 0..V_TOTAL-1 (750), free-running from reset. v increments when h wraps, and v wraps to 0 after 749.
- Active region = h<H_ACTIVE && v<V_ACTIVE.
- hsync asserted for h in [H_ACTIVE+H_FP, +H_SYNC) = [1390,1430).
- vsync asserted for v in [V_ACTIVE+V_FP, +V_SYNC) = [725,730).
- All outputs are registered: 1-cycle latency from counter state, and de/sync/rgb are mutually aligned.
- Write side:
  - i_rgb8_valid && !full -> push.
  - valid && full -> drop and set o_overflow.
  - A simultaneous push and pop at full is accepted, and the level is unchanged.
- Read side: first-word-fall-through. A pop occurs only in STREAM during the active region with buffer non-empty. o_rgb8 takes the head entry in that same cycle.
- A push in a cycle with level=0 is not bypassed. A pop in that cycle sees empty.
- FSM states:
  - IDLE: o_de still follows timing, o_rgb8=0, no pops. Goes to STREAM when level>=PREFILL at frame end (h=1649,v=749).
  - STREAM: pops per active pixel. If empty on an active pixel: o_rgb8=0, set o_underflow, go to RESYNC.
  - RESYNC: no pops. At frame end, flush the buffer (pointers reset; a same-cycle write is discarded), then go to IDLE.
- o_streaming=1 only in STREAM.
- i_clr_err clears both sticky flags. If clear and set occur in the same cycle, set wins.
- o_buf_level updates 1 cycle after a push/pop. Width is BUF_AW+1, so full reads 2048.

Optional Feature:
HDMI_ALIGNER_PATTERN_EN
- Defined: adds input i_pattern_sel (1 bit). When high, active pixels show 8 vertical colour bars of 160 px each: white, yellow, cyan, green, magenta, red, blue, black (0xFFFFFF, 0xFFFF00, 0x00FFFF, 0x00FF00, 0xFF00FF, 0xFF0000, 0x0000FF, 0x000000). No pops occur while it is high, the FSM is held in its current state, and writes continue.
- Undefined: the port and bar logic are absent.

Decomposition:
- Package hdmi_video_pkg: 720p timing constants, H_TOTAL/V_TOTAL localparams, FSM state enum (IDLE, STREAM, RESYNC), colour-bar constants.
- Sub-module pixel_fwft_fifo: single-clock FWFT FIFO with level/full/empty and a flush input.
- Timing counters and the FSM live in the top module.

Test Plan:
1. Reset, then no input -> o_de first rises 1 cycle after h=0,v=0. o_hsync pulses 40 clocks starting 1390 clocks after line start. o_vsync spans lines 725-729. o_rgb8=0 throughout, o_streaming=0.
2. Push 1280 pixels (value = index) mid-frame -> stay IDLE until frame end. Next frame, first active o_rgb8=0x000000, then 0x000001, and so on, with o_streaming=1.
3. Prefill 1280, then stop input -> underflow at frame line 1, pixel 0: o_rgb8=0 and o_underflow=1. RESYNC, flush at frame end, then IDLE with o_buf_level=0.
4. Push 2049 pixels with no reads -> o_buf_level=2048, o_overflow=1. Pulse i_clr_err -> o_overflow=0.
5. Assert i_rst_n=0 mid-STREAM, asynchronously -> all outputs return to reset values within the same cycle, and the buffer is empty.
6. With HDMI_ALIGNER_PATTERN_EN and i_pattern_sel=1 -> pixel 0 = 0xFFFFFF, pixel 160 = 0xFFFF00, pixel 1279 = 0x000000, and o_buf_level does not decrease.
